gerador_referencia_vf: RTL

GERADOR_REFERENCIA_VF -- requirements
Module: gerador_referencia_vf

---
 rtl/gerador_referencia_vf.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gerador_referencia_vf.sv
// V/f sine reference generator: ramped frequency, 40-bit phase accumulator,
// quarter-wave sine ROM scaled by a V/f amplitude, offset-binary output.
module gerador_referencia_vf #(
    parameter int F_MAX    = 800,
    parameter int RAMP_DIV = 50000,
    parameter int K_INC    = 2199,
    parameter int KVF      = 1748,
    parameter int V_BOOST  = 0
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  freq_cmd,
    output logic [11:0] referencia,
    output logic [9:0]  freq_atual,
    output logic        em_rampa,
    output logic        zero_cross
);

    localparam int              PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [9:0]      F_MAX_V    = 10'(F_MAX);
    localparam logic [39:0]     K_INC_V    = 40'(K_INC);

    typedef logic [1023:0][10:0] rom_t;

    // mag[i] = round(2047*sin(pi/2*(i+0.5)/1024)), Taylor series evaluated at elaboration
    function automatic rom_t build_rom();
        rom_t t;
        real  x, x2, term, acc;
        int   i;
        for (int hi = 0; hi < 32; hi++) begin
            for (int lo = 0; lo < 32; lo++) begin
                i    = hi * 32 + lo;
                x    = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / 1024.0;
                x2   = x * x;
                term = x;
                acc  = x;
                for (int k = 1; k < 10; k++) begin
                    term = -term * x2 / real'((2 * k) * (2 * k + 1));
                    acc  = acc + term;
                end
                t[i] = 11'($rtoi(2047.0 * acc + 0.5));
            end
        end
        return t;
    endfunction

    // NOTE: the ROM is a constant, so it carries no reset; only its registered read is cleared.
    localparam rom_t MAG_ROM = build_rom();

    logic [1:0]    rst_sync;
    logic          hold;
    logic [9:0]    target;
    logic [9:0]    freq_next;
    logic [PW-1:0] presc, presc_next;
    logic [31:0]   amp_sum;
    logic [10:0]   amp_next, amp;
    logic [39:0]   phase;
    logic [1:0]    q_s1;
    logic [9:0]    addr_s1;
    logic          neg_s1, neg_s2, neg_s3;
    logic          zc_s1, zc_s2, zc_s3;
    logic [10:0]   mag_s2;
    logic [10:0]   s_s3;

    assign hold = rst_sync[1];

    // Reset release synchroniser: state stays cleared until rst has been low for two edges
    always_ff @(posedge clk_50 or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) rst_sync <= 2'b11;
        else     rst_sync <= {rst_sync[0], 1'b0};
    end

    // Effective target, prescaler and one-unit ramp step toward the target
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch behind.
        target     = '0;
        freq_next  = freq_atual;
        presc_next = presc;
        if (enable) target = (freq_cmd > F_MAX_V) ? F_MAX_V : freq_cmd;
        if (freq_atual == target) begin
            presc_next = '0;
        end else if (presc == PRESC_LAST) begin
            presc_next = '0;
            freq_next  = (freq_atual < target) ? freq_atual + 10'd1 : freq_atual - 10'd1;
        end else begin
            presc_next = presc + 1'b1;
        end
    end

    // V/f amplitude with boost, clamped at unity (1024 in Q10)
    always_comb begin
        amp_sum  = 32'(V_BOOST) + ((32'(freq_atual) * 32'(KVF)) >> 10);
        amp_next = (amp_sum > 32'd1024) ? 11'd1024 : amp_sum[10:0];
    end

    // Ramp state, em_rampa tracks the post-edge frequency so it falls on arrival
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            freq_atual <= '0;
            presc      <= '0;
            em_rampa   <= 1'b0;
            amp        <= '0;
        end else if (hold) begin
            freq_atual <= '0;
            presc      <= '0;
            em_rampa   <= 1'b0;
            amp        <= '0;
        end else begin
            freq_atual <= freq_next;
            presc      <= presc_next;
            em_rampa   <= (freq_next != target);
            amp        <= amp_next;
        end
    end

    // Phase accumulator and 4-stage output pipeline with sign and wrap flag carried along
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            phase      <= '0;
            q_s1       <= '0;
            addr_s1    <= '0;
            neg_s1     <= 1'b0;
            zc_s1      <= 1'b0;
            mag_s2     <= '0;
            neg_s2     <= 1'b0;
            zc_s2      <= 1'b0;
            s_s3       <= '0;
            neg_s3     <= 1'b0;
            zc_s3      <= 1'b0;
            referencia <= 12'd2048;
            zero_cross <= 1'b0;
        end else if (hold) begin
            phase      <= '0;
            q_s1       <= '0;
            addr_s1    <= '0;
            neg_s1     <= 1'b0;
            zc_s1      <= 1'b0;
            mag_s2     <= '0;
            neg_s2     <= 1'b0;
            zc_s2      <= 1'b0;
            s_s3       <= '0;
            neg_s3     <= 1'b0;
            zc_s3      <= 1'b0;
            referencia <= 12'd2048;
            zero_cross <= 1'b0;
        end else begin
            phase      <= phase + 40'(freq_atual) * K_INC_V;
            // odd quadrants read the table backwards; upper half-cycle is negative
            q_s1       <= phase[39:38];
            addr_s1    <= phase[38] ? ~phase[37:28] : phase[37:28];
            neg_s1     <= phase[39];
            zc_s1      <= (phase[39:38] == 2'd0) && (q_s1 == 2'd3);
            mag_s2     <= MAG_ROM[addr_s1];
            neg_s2     <= neg_s1;
            zc_s2      <= zc_s1;
            s_s3       <= 11'((22'(mag_s2) * 22'(amp)) >> 10);
            neg_s3     <= neg_s2;
            zc_s3      <= zc_s2;
            referencia <= neg_s3 ? 12'd2048 - {1'b0, s_s3} : 12'd2048 + {1'b0, s_s3};
            zero_cross <= zc_s3;
        end
    end

endmodule
